// File: rtl/acc_alu_ctrl_core.sv
// Execution core of the 8-bit accumulator computer: opcode decoder, accumulator
// register and the small ALU that feeds the register file, memory and PC.
module acc_alu_ctrl_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       opcode,
  input  logic [4:0]       imm,
  input  logic [WIDTH-1:0] reg_data,
  input  logic [WIDTH-1:0] reg_buf,
  input  logic [WIDTH-1:0] pc_addr,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] alu_out,
  output logic [1:0]       alu_ctl,
  output logic             reg_we,
  output logic             mem_we,
  output logic             branch,
  output logic             lw_sel,
  output logic             mem_sel,
  output logic             acc_we,
  output logic             acc_sel,
  output logic             zero
);

  // Opcode encodings (instr[7:5])
  localparam logic [2:0] OpNop = 3'b000;
  localparam logic [2:0] OpLdi = 3'b001;
  localparam logic [2:0] OpLda = 3'b010;
  localparam logic [2:0] OpAdd = 3'b011;
  localparam logic [2:0] OpSub = 3'b100;
  localparam logic [2:0] OpLw  = 3'b101;
  localparam logic [2:0] OpSw  = 3'b110;
  localparam logic [2:0] OpJal = 3'b111;

  // ALU operation selects
  localparam logic [1:0] AluAdd  = 2'b00;
  localparam logic [1:0] AluSub  = 2'b01;
  localparam logic [1:0] AluAnd  = 2'b10;
  localparam logic [1:0] AluLink = 2'b11;

  // Raw decode before the reset gate on the write enables
  logic dec_reg_we;
  logic dec_mem_we;
  logic dec_branch;
  logic dec_acc_we;

  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] acc_q;

  // Decode control signals from the opcode
  always_comb begin
    alu_ctl    = AluAdd;
    dec_reg_we = 1'b0;
    dec_mem_we = 1'b0;
    dec_branch = 1'b0;
    dec_acc_we = 1'b0;
    lw_sel     = 1'b0;
    mem_sel    = 1'b0;
    acc_sel    = 1'b0;
    unique case (opcode)
      OpNop: ;
      OpLdi: begin
        dec_acc_we = 1'b1;
        acc_sel    = 1'b1;
      end
      OpLda: begin
        dec_acc_we = 1'b1;
      end
      OpAdd: begin
        alu_ctl    = AluAdd;
        dec_reg_we = 1'b1;
      end
      OpSub: begin
        alu_ctl    = AluSub;
        dec_reg_we = 1'b1;
      end
      OpLw: begin
        mem_sel    = 1'b1;
        lw_sel     = 1'b1;
        dec_reg_we = 1'b1;
      end
      OpSw: begin
        mem_sel    = 1'b1;
        dec_mem_we = 1'b1;
      end
      OpJal: begin
        alu_ctl    = AluLink;
        dec_branch = 1'b1;
        dec_reg_we = 1'b1;
      end
      default: ;
    endcase
  end

  // No state-changing strobe may leave the core while reset is held;
  // selects keep decoding so downstream muxes stay stable.
  always_comb begin
    reg_we = dec_reg_we & reset;
    mem_we = dec_mem_we & reset;
    branch = dec_branch & reset;
    acc_we = dec_acc_we & reset;
  end

  // Accumulator input mux: register-file data or sign-extended immediate
  always_comb begin
    imm_ext = {{(WIDTH-5){imm[4]}}, imm};
    acc_d   = acc_sel ? imm_ext : reg_data;
  end

  // Accumulator register with asynchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (acc_we) begin
      acc_q <= acc_d;
    end
  end

  assign acc_out = acc_q;

  // ALU: A is the accumulator, B is the latched register operand
  always_comb begin
    alu_out = '0;
    unique case (alu_ctl)
      AluAdd:  alu_out = acc_q + reg_buf;
      AluSub:  alu_out = acc_q - reg_buf;
      AluAnd:  alu_out = acc_q & reg_buf;
      AluLink: alu_out = pc_addr;
      default: alu_out = '0;
    endcase
  end

  // Zero flag on the ALU result
  always_comb begin
    zero = (alu_out == '0);
  end

endmodule

// File: tb/tb_acc_alu_ctrl_core.sv
// Directed bench for acc_alu_ctrl_core: expectations are queued when stimulus
// is applied and popped against the DUT outputs once they have settled.
module tb_acc_alu_ctrl_core;

  logic       clk;
  logic       reset;
  logic [2:0] opcode;
  logic [4:0] imm;
  logic [7:0] reg_data;
  logic [7:0] reg_buf;
  logic [7:0] pc_addr;
  logic [7:0] acc_out;
  logic [7:0] alu_out;
  logic [1:0] alu_ctl;
  logic       reg_we;
  logic       mem_we;
  logic       branch;
  logic       lw_sel;
  logic       mem_sel;
  logic       acc_we;
  logic       acc_sel;
  logic       zero;

  acc_alu_ctrl_core #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .imm      (imm),
    .reg_data (reg_data),
    .reg_buf  (reg_buf),
    .pc_addr  (pc_addr),
    .acc_out  (acc_out),
    .alu_out  (alu_out),
    .alu_ctl  (alu_ctl),
    .reg_we   (reg_we),
    .mem_we   (mem_we),
    .branch   (branch),
    .lw_sel   (lw_sel),
    .mem_sel  (mem_sel),
    .acc_we   (acc_we),
    .acc_sel  (acc_sel),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    SigAcc, SigAlu, SigCtl, SigRegWe, SigMemWe, SigBranch,
    SigLwSel, SigMemSel, SigAccWe, SigAccSel, SigZero
  } sig_e;

  typedef struct {
    string      tag;
    sig_e       sig;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   tests;
  int   fails;

  function automatic logic [7:0] observe(sig_e s);
    case (s)
      SigAcc:    return acc_out;
      SigAlu:    return alu_out;
      SigCtl:    return {6'b0, alu_ctl};
      SigRegWe:  return {7'b0, reg_we};
      SigMemWe:  return {7'b0, mem_we};
      SigBranch: return {7'b0, branch};
      SigLwSel:  return {7'b0, lw_sel};
      SigMemSel: return {7'b0, mem_sel};
      SigAccWe:  return {7'b0, acc_we};
      SigAccSel: return {7'b0, acc_sel};
      SigZero:   return {7'b0, zero};
      default:   return 8'hxx;
    endcase
  endfunction

  task automatic push(input string tag, input sig_e s, input logic [7:0] e);
    exp_t item;
    item.tag = tag;
    item.sig = s;
    item.exp = e;
    sb_q.push_back(item);
  endtask

  // Drain the scoreboard against the current, settled outputs
  task automatic check_all();
    exp_t       item;
    logic [7:0] obs;
    while (sb_q.size() > 0) begin
      item = sb_q.pop_front();
      obs  = observe(item.sig);
      tests++;
      assert (obs === item.exp) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", item.tag, obs, item.exp);
      end
    end
  endtask

  // Advance one rising edge and sample away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] im, input logic [7:0] rd,
                       input logic [7:0] rb, input logic [7:0] pc);
    opcode   = op;
    imm      = im;
    reg_data = rd;
    reg_buf  = rb;
    pc_addr  = pc;
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    drive(3'b001, 5'h05, 8'h00, 8'h00, 8'h00);

    // Reset held across edges with LDI presented
    tick();
    tick();
    push("rst_acc", SigAcc, 8'h00);
    push("rst_acc_we", SigAccWe, 8'h00);
    push("rst_acc_sel", SigAccSel, 8'h01);
    check_all();

    // Release reset: LDI 5 lands on the next edge
    reset = 1'b1;
    #1;
    push("ldi_acc_we", SigAccWe, 8'h01);
    check_all();
    tick();
    push("ldi_5", SigAcc, 8'h05);
    check_all();

    // LDI negative immediate sign-extends
    drive(3'b001, 5'b11110, 8'h00, 8'h00, 8'h00);
    tick();
    push("ldi_neg", SigAcc, 8'hFE);
    check_all();

    // LDI largest positive immediate
    drive(3'b001, 5'b01111, 8'h00, 8'h00, 8'h00);
    tick();
    push("ldi_0f", SigAcc, 8'h0F);
    check_all();

    // LDA from register data
    drive(3'b010, 5'h00, 8'h3C, 8'h00, 8'h00);
    push("lda_sel", SigAccSel, 8'h00);
    push("lda_we", SigAccWe, 8'h01);
    check_all();
    tick();
    push("lda_acc", SigAcc, 8'h3C);
    check_all();

    // ADD with carry discarded: F0 + 20 = 10
    drive(3'b001, 5'b10000, 8'h00, 8'h00, 8'h00);
    tick();
    push("ldi_f0", SigAcc, 8'hF0);
    check_all();
    drive(3'b011, 5'h00, 8'h00, 8'h20, 8'h00);
    push("add_out", SigAlu, 8'h10);
    push("add_ctl", SigCtl, 8'h00);
    push("add_reg_we", SigRegWe, 8'h01);
    push("add_lw_sel", SigLwSel, 8'h00);
    push("add_zero", SigZero, 8'h00);
    push("add_acc_we", SigAccWe, 8'h00);
    check_all();
    tick();
    push("add_hold", SigAcc, 8'hF0);
    check_all();

    // SUB to zero sets the flag
    drive(3'b010, 5'h00, 8'h20, 8'h00, 8'h00);
    tick();
    drive(3'b100, 5'h00, 8'h00, 8'h20, 8'h00);
    push("sub_out0", SigAlu, 8'h00);
    push("sub_ctl", SigCtl, 8'h01);
    push("sub_zero", SigZero, 8'h01);
    check_all();

    // SUB wrap: 0 - 1 = FF
    drive(3'b001, 5'h00, 8'h00, 8'h00, 8'h00);
    tick();
    drive(3'b100, 5'h00, 8'h00, 8'h01, 8'h00);
    push("sub_wrap", SigAlu, 8'hFF);
    push("sub_wrap_zero", SigZero, 8'h00);
    check_all();

    // LW decode; accumulator holds
    drive(3'b101, 5'h00, 8'h55, 8'h00, 8'h00);
    push("lw_mem_sel", SigMemSel, 8'h01);
    push("lw_lw_sel", SigLwSel, 8'h01);
    push("lw_reg_we", SigRegWe, 8'h01);
    push("lw_mem_we", SigMemWe, 8'h00);
    check_all();
    tick();
    push("lw_hold", SigAcc, 8'h00);
    check_all();

    // SW decode; accumulator holds
    drive(3'b110, 5'h00, 8'h55, 8'h00, 8'h00);
    push("sw_mem_sel", SigMemSel, 8'h01);
    push("sw_mem_we", SigMemWe, 8'h01);
    push("sw_reg_we", SigRegWe, 8'h00);
    check_all();
    tick();
    push("sw_hold", SigAcc, 8'h00);
    check_all();

    // JAL: link PC through the ALU and branch
    drive(3'b111, 5'h00, 8'h00, 8'h40, 8'h12);
    push("jal_ctl", SigCtl, 8'h03);
    push("jal_out", SigAlu, 8'h12);
    push("jal_branch", SigBranch, 8'h01);
    push("jal_reg_we", SigRegWe, 8'h01);
    push("jal_lw_sel", SigLwSel, 8'h00);
    check_all();

    // NOP: nothing enabled
    drive(3'b000, 5'h00, 8'h00, 8'h00, 8'h00);
    push("nop_reg_we", SigRegWe, 8'h00);
    push("nop_branch", SigBranch, 8'h00);
    push("nop_acc_we", SigAccWe, 8'h00);
    push("nop_mem_sel", SigMemSel, 8'h00);
    check_all();

    // Async reset between edges clears acc and gates enables immediately
    drive(3'b010, 5'h00, 8'h7F, 8'h00, 8'h00);
    tick();
    push("pre_rst_acc", SigAcc, 8'h7F);
    check_all();
    drive(3'b111, 5'h00, 8'h00, 8'h40, 8'h12);
    #1;
    reset = 1'b0;
    #1;
    push("arst_acc", SigAcc, 8'h00);
    push("arst_branch", SigBranch, 8'h00);
    push("arst_reg_we", SigRegWe, 8'h00);
    push("arst_ctl", SigCtl, 8'h03);
    check_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #100000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
